// File: rtl/approx_adder_arbiter.sv
// approx_adder_arbiter
//   Shares a single Approx_adder among N_REQ requesters. Requests are granted
//   round-robin, each operation runs IDLE -> EXEC -> RESP, and the registered
//   approximate result is returned with the exact result and requester ID.
//   Running error statistics characterise the adder build (APPROX_K).
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot)
//   req_in1/req_in2       packed operands, requester i uses [i*W +: W]
//   req_add_sub           1 = in1 - in2, 0 = in1 + in2
//   res_valid/res_ready   result handshake
//   res_data/res_exact    approximate / exact result (W+1 bits)
//   res_id                index of the requester that issued the operation
//   stat_clear            synchronous clear of the statistics
//   stat_ops/stat_err_sum/stat_err_max   error statistics

// Approx_adder
//   W-bit add/subtract with a lower-part-OR approximation on the low APPROX_K
//   bits. APPROX_K = 0 gives the exact (NADA) adder.
//
// Ports
//   i_in1, i_in2   operands
//   i_add_sub      1 = subtract, 0 = add
//   o_res          W+1-bit result, modulo 2^(W+1)
module Approx_adder #(
  parameter int W        = 13,
  parameter int APPROX_K = 0
) (
  input  logic [W-1:0] i_in1,
  input  logic [W-1:0] i_in2,
  input  logic         i_add_sub,
  output logic [W:0]   o_res
);

  logic [W:0] w_a;
  logic [W:0] w_b;

  // Subtraction uses the inverted second operand; the +1 carry-in is only
  // honoured by the exact build.
  assign w_a = {1'b0, i_in1};
  assign w_b = i_add_sub ? ~{1'b0, i_in2} : {1'b0, i_in2};

  generate
    if (APPROX_K == 0) begin : g_exact
      assign o_res = w_a + w_b + {{W{1'b0}}, i_add_sub};
    end else begin : g_loa
      logic [APPROX_K-1:0] w_lo;
      logic [W-APPROX_K:0] w_hi;
      logic                w_carry;

      // Low bits are plain OR; the AND of their top bits stands in for the
      // carry into the exact upper adder.
      assign w_lo    = w_a[APPROX_K-1:0] | w_b[APPROX_K-1:0];
      assign w_carry = w_a[APPROX_K-1] & w_b[APPROX_K-1];
      assign w_hi    = w_a[W:APPROX_K] + w_b[W:APPROX_K] + {{(W-APPROX_K){1'b0}}, w_carry};
      assign o_res   = {w_hi, w_lo};
    end
  endgenerate

endmodule

// State table
//   state | meaning
//   IDLE  | waiting for a request; grants one round-robin and latches operands
//   EXEC  | adder evaluates latched operands; results and error registered
//   RESP  | res_valid high, result held until res_ready
module approx_adder_arbiter #(
  parameter int W        = 13,
  parameter int N_REQ    = 4,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int CNT_W    = 24,
  parameter int ERR_W    = 32,
  parameter int APPROX_K = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_in1,
  input  logic [N_REQ*W-1:0]   req_in2,
  input  logic [N_REQ-1:0]     req_add_sub,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W:0]           res_data,
  output logic [W:0]           res_exact,
  output logic [ID_W-1:0]      res_id,
  input  logic                 stat_clear,
  output logic [CNT_W-1:0]     stat_ops,
  output logic [ERR_W-1:0]     stat_err_sum,
  output logic [W+1:0]         stat_err_max
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  r_id;
  logic [W-1:0]     r_in1;
  logic [W-1:0]     r_in2;
  logic             r_add_sub;
  logic [W:0]       r_res_data;
  logic [W:0]       r_res_exact;
  logic [ID_W-1:0]  r_res_id;
  logic [W+1:0]     r_err;
  logic [CNT_W-1:0] r_ops;
  logic [ERR_W-1:0] r_err_sum;
  logic [W+1:0]     r_err_max;

  logic             w_gnt_found;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [W:0]       w_adder_res;
  logic [W:0]       w_exact;
  logic [W+1:0]     w_diff;
  logic [W+1:0]     w_err;
  logic             w_hs;
  logic [ERR_W:0]   w_sum_ext;

  // Round-robin search starting one past the last grant.
  always_comb begin
    int v_pos;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    v_pos       = 0;
    for (int j = 0; j < N_REQ; j++) begin
      v_pos = int'(r_last) + 1 + j;
      if (v_pos >= N_REQ) v_pos = v_pos - N_REQ;
      if (!w_gnt_found && req_valid[ID_W'(v_pos)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = ID_W'(v_pos);
      end
    end
  end

  // Gated with rst so nothing is accepted while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst && r_state == S_IDLE && w_gnt_found) req_ready[w_gnt_idx] = 1'b1;
  end

  Approx_adder #(
    .W        (W),
    .APPROX_K (APPROX_K)
  ) u_adder (
    .i_in1     (r_in1),
    .i_in2     (r_in2),
    .i_add_sub (r_add_sub),
    .o_res     (w_adder_res)
  );

  assign w_exact = r_add_sub ? ({1'b0, r_in1} - {1'b0, r_in2})
                             : ({1'b0, r_in1} + {1'b0, r_in2});

  // Both results are treated as signed W+1-bit values; the magnitude of
  // their difference always fits W+2 bits unsigned.
  assign w_diff = {w_adder_res[W], w_adder_res} - {w_exact[W], w_exact};
  assign w_err  = w_diff[W+1] ? (~w_diff + (W+2)'(1)) : w_diff;

  assign w_hs      = (r_state == S_RESP) && res_ready;
  assign w_sum_ext = {1'b0, r_err_sum} + {{(ERR_W-W-1){1'b0}}, r_err};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_last      <= ID_W'(N_REQ - 1);
      r_id        <= '0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_add_sub   <= 1'b0;
      r_res_data  <= '0;
      r_res_exact <= '0;
      r_res_id    <= '0;
      r_err       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_in1     <= req_in1[w_gnt_idx*W +: W];
            r_in2     <= req_in2[w_gnt_idx*W +: W];
            r_add_sub <= req_add_sub[w_gnt_idx];
            r_last    <= w_gnt_idx;
            r_id      <= w_gnt_idx;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res_data  <= w_adder_res;
          r_res_exact <= w_exact;
          r_err       <= w_err;
          r_res_id    <= r_id;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Clear takes precedence over a coincident handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ops     <= '0;
      r_err_sum <= '0;
      r_err_max <= '0;
    end else if (stat_clear) begin
      r_ops     <= '0;
      r_err_sum <= '0;
      r_err_max <= '0;
    end else if (w_hs) begin
      if (r_ops != '1) r_ops <= r_ops + 1'b1;
      r_err_sum <= w_sum_ext[ERR_W] ? '1 : w_sum_ext[ERR_W-1:0];
      if (r_err > r_err_max) r_err_max <= r_err;
    end
  end

  assign res_valid    = (r_state == S_RESP);
  assign res_data     = r_res_data;
  assign res_exact    = r_res_exact;
  assign res_id       = r_res_id;
  assign stat_ops     = r_ops;
  assign stat_err_sum = r_err_sum;
  assign stat_err_max = r_err_max;

endmodule

// File: tb/tb_approx_adder_arbiter.sv
module tb_approx_adder_arbiter;

  localparam int W     = 13;
  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 24;
  localparam int ERR_W = 32;
  localparam int K     = 3;
  localparam int M1    = 1 << (W + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N*W-1:0]       req_in1 = '0;
  logic [N*W-1:0]       req_in2 = '0;
  logic [N-1:0]         req_add_sub = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [W:0]           res_data;
  logic [W:0]           res_exact;
  logic [ID_W-1:0]      res_id;
  logic                 stat_clear = 1'b0;
  logic [CNT_W-1:0]     stat_ops;
  logic [ERR_W-1:0]     stat_err_sum;
  logic [W+1:0]         stat_err_max;

  always #5 clk = ~clk;

  approx_adder_arbiter #(
    .W(W), .N_REQ(N), .ID_W(ID_W), .CNT_W(CNT_W), .ERR_W(ERR_W), .APPROX_K(K)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_add_sub(req_add_sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_exact(res_exact), .res_id(res_id),
    .stat_clear(stat_clear), .stat_ops(stat_ops),
    .stat_err_sum(stat_err_sum), .stat_err_max(stat_err_max)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rnd_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int approx;
    int exact;
    int acc;
  } exp_t;

  exp_t q[$];

  // Reference: exact result modulo 2^(W+1).
  function automatic int f_exact(int a, int b, bit sub);
    return sub ? (a - b + M1) % M1 : (a + b) % M1;
  endfunction

  // Reference lower-part-OR adder: low K bits are a OR b', upper part adds
  // with the AND of bit K-1 as carry; subtraction drops the +1.
  function automatic int f_approx(int a, int b, bit sub);
    int bb, lo, c, hi;
    if (K == 0) return f_exact(a, b, sub);
    bb = sub ? (M1 - 1 - b) : b;
    lo = (a | bb) % (1 << K);
    c  = ((a / (1 << (K - 1))) % 2) * ((bb / (1 << (K - 1))) % 2);
    hi = (a / (1 << K) + bb / (1 << K) + c) % (1 << (W + 1 - K));
    return hi * (1 << K) + lo;
  endfunction

  function automatic int f_err(int ap, int ex);
    int sa, se, d;
    sa = (ap >= M1 / 2) ? ap - M1 : ap;
    se = (ex >= M1 / 2) ? ex - M1 : ex;
    d  = sa - se;
    return (d < 0) ? -d : d;
  endfunction

  function automatic int f_rr(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic check(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_op(int i, int a, int b, bit s);
    req_in1[i*W +: W] = W'(a);
    req_in2[i*W +: W] = W'(b);
    req_add_sub[i]    = s;
  endtask

  // Issue tracker: predicts grants and pushes expected results.
  int  t_last = N - 1;
  bit  t_busy = 1'b0;
  always @(negedge clk) begin
    int   g, a, b;
    bit   s;
    exp_t e;
    if (!rst) begin
      t_busy = 1'b0;
      t_last = N - 1;
      check("ready_in_reset", req_ready, 0);
    end else if (!t_busy) begin
      g = f_rr(req_valid, t_last);
      if (g < 0) begin
        check("ready_no_req", req_ready, 0);
      end else begin
        check("grant_onehot", req_ready, longint'(1) << g);
        a = int'(req_in1[g*W +: W]);
        b = int'(req_in2[g*W +: W]);
        s = req_add_sub[g];
        e.id     = g;
        e.approx = f_approx(a, b, s);
        e.exact  = f_exact(a, b, s);
        e.acc    = cyc;
        q.push_back(e);
        t_last = g;
        t_busy = 1'b1;
      end
    end else begin
      check("ready_busy", req_ready, 0);
      if (res_valid && res_ready) t_busy = 1'b0;
    end
  end

  // Monitor: pops and compares whenever a result is presented.
  longint m_ops = 0, m_sum = 0, m_max = 0;
  bit     prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   err;
    if (!rst) begin
      q.delete();
      m_ops = 0; m_sum = 0; m_max = 0;
      prev_v = 1'b0;
      check("rst_res_valid", res_valid, 0);
      check("rst_stat_ops", stat_ops, 0);
      check("rst_stat_err_sum", stat_err_sum, 0);
      check("rst_stat_err_max", stat_err_max, 0);
    end else begin
      check("stat_ops", stat_ops, m_ops);
      check("stat_err_sum", stat_err_sum, m_sum);
      check("stat_err_max", stat_err_max, m_max);
      if (res_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: res_valid high, expected none (cycle %0d)", cyc);
        end else begin
          e = q[0];
          if (!prev_v) check("latency", cyc, e.acc + 2);
          check("res_id", res_id, e.id);
          check("res_data", res_data, e.approx);
          check("res_exact", res_exact, e.exact);
          if (res_ready) begin
            err = f_err(e.approx, e.exact);
            void'(q.pop_front());
            if (!stat_clear) begin
              m_ops = (m_ops == (longint'(1) << CNT_W) - 1) ? m_ops : m_ops + 1;
              m_sum = (m_sum + err > (longint'(1) << ERR_W) - 1) ?
                      (longint'(1) << ERR_W) - 1 : m_sum + err;
              if (err > m_max) m_max = err;
            end
          end
        end
      end
      if (stat_clear) begin
        m_ops = 0; m_sum = 0; m_max = 0;
      end
      prev_v = res_valid;
    end
  end

  task automatic step();
    logic [N-1:0] gv;
    @(negedge clk);
    gv = req_ready;
    @(posedge clk);
    #1;
    if (rnd_on) begin
      for (int i = 0; i < N; i++)
        if (gv[i]) set_op(i, $urandom_range(0, (1 << W) - 1),
                          $urandom_range(0, (1 << W) - 1), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic wait_valid(int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_valid: res_valid not seen within %0d cycles", max_cyc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++)
      set_op(i, $urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1),
             1'($urandom_range(0, 1)));
    set_op(0, 100, 30, 1'b0);
    set_op(1, 5, 9, 1'b1);
    req_valid = 4'hF;

    // Reset held with requests pending and res_ready toggling.
    repeat (4) begin
      @(posedge clk);
      #1 res_ready = ~res_ready;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    res_ready = 1'b1;

    // Round-robin with all requesters valid: 0,1,2,3,0,1.
    repeat (18) step();
    rnd_on = 1'b1;

    // Backpressure for 5 cycles while in RESP.
    res_ready = 1'b0;
    wait_valid(10);
    repeat (5) step();
    res_ready = 1'b1;
    step();

    // stat_clear coincident with a handshake.
    res_ready = 1'b0;
    wait_valid(10);
    stat_clear = 1'b1;
    res_ready  = 1'b1;
    @(posedge clk);
    #1 stat_clear = 1'b0;
    @(negedge clk);
    check("clear_hs_ops", stat_ops, 0);
    check("clear_hs_sum", stat_err_sum, 0);
    check("clear_hs_max", stat_err_max, 0);

    // Randomised traffic.
    repeat (400) begin
      req_valid  = N'($urandom);
      res_ready  = ($urandom_range(0, 3) != 0);
      stat_clear = ($urandom_range(0, 49) == 0);
      step();
    end
    stat_clear = 1'b0;

    // Reset asserted while an operation is in EXEC.
    req_valid = 4'hF;
    res_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("midop_grant_seen", (req_ready != '0), 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midop_res_valid", res_valid, 0);
    check("midop_res_data", res_data, 0);
    check("midop_res_exact", res_exact, 0);
    check("midop_res_id", res_id, 0);
    check("midop_stat_ops", stat_ops, 0);
    check("midop_req_ready", req_ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (12) step();

    // Drain.
    req_valid = '0;
    res_ready = 1'b1;
    repeat (6) step();
    check("drain_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/approx_adder_arbiter.md
Name: approx_adder_arbiter

Overview:
- Shares one `Approx_adder` instance (W-bit operands, `add_sub`, W+1-bit result) among N_REQ requesters.
- Grants requesters round-robin and sequences each operation through a 3-state FSM.
- Returns the registered approximate result together with the exact result and requester ID.
- Keeps running error statistics (operation count, summed absolute error, maximum error) for on-silicon characterisation of the adder configuration selected at build time.

Parameters:
- W, 13, operand width passed to `Approx_adder`.
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; ID_W = clog2(N_REQ).
- CNT_W, 24, width of the operation counter.
- ERR_W, 32, width of the error accumulator.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero.
- req_in1  in  N_REQ*W  packed operand 1; requester i uses bits [i*W +: W].
- req_in2  in  N_REQ*W  packed operand 2.
- req_add_sub  in  N_REQ  1 = subtract (in1-in2), 0 = add.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_data  out  W+1  approximate result from `Approx_adder`.
- res_exact  out  W+1  exact result, modulo 2^(W+1).
- res_id  out  ID_W  index of the requester that issued the operation.
- stat_clear  in  1  synchronous clear of statistics.
- stat_ops  out  CNT_W  completed operations.
- stat_err_sum  out  ERR_W  sum of absolute errors.
- stat_err_max  out  W+2  largest absolute error seen.

Behaviour:
Reset (rst=0, asynchronous):
- FSM goes to IDLE.
- res_valid, res_data, res_exact, res_id and all stat_* are 0.
- Round-robin pointer `last` = N_REQ-1, so requester 0 has first priority.
- An in-flight operation is dropped without any notification.

FSM states are IDLE, EXEC and RESP.

IDLE:
- If any req_valid is high, g = first index with req_valid set, searching last+1, last+2, ... modulo N_REQ.
- req_ready[g]=1 combinationally in this cycle only.
- On the clock edge: latch in1, in2, add_sub of g into operand registers; set last=g, id=g; go to EXEC.
- If no request is valid, stay in IDLE with req_ready=0.

EXEC (one cycle):
- Operand registers drive `Approx_adder`.
- On the clock edge:
  - res_data <= adder res.
  - res_exact <= add ? {0,in1}+{0,in2} : {0,in1}-{0,in2}, truncated to W+1 bits.
  - err_reg <= |signed(res_data) - signed(res_exact)|, computed in W+2 bits; the magnitude fits W+2 unsigned.
  - res_id <= id.
  - Go to RESP.

RESP:
- res_valid=1.
- res_data, res_exact and res_id are held stable until res_valid && res_ready.
- On handshake: update statistics, then go to IDLE. res_valid is 0 the next cycle.

Handshake and timing:
- req_ready is 0 in EXEC and RESP.
- Latency is accept at edge T, res_valid high from T+2.
- Maximum throughput is one operation per 3 cycles with res_ready held at 1.

Statistics, updated only on a result handshake:
- stat_ops += 1, saturating at all-ones.
- stat_err_sum += err_reg, saturating at all-ones.
- stat_err_max = max(stat_err_max, err_reg).

stat_clear:
- Zeroes all three statistics.
- If it coincides with a handshake, clear wins and that operation is not counted.
- stat_clear does not affect the FSM or the result path.

Boundary rules:
- A requester dropping req_valid while not granted: no effect.
- A new request arriving during EXEC/RESP waits; its fairness is preserved by the pointer.
- The same requester is granted back-to-back only if no other requester is valid.

Test Plan:
1. Reset: hold rst=0 with req_valid=4'hF and res_ready toggling -> req_ready=0, res_valid=0, all stat_* 0. Release reset -> grant req 0 in the first cycle.
2. Single add, with `Approx_adder` built in exact (NADA) configuration:
   - Stimulus: req 0, in1=100, in2=30, add_sub=0; accepted at T; res_ready=1.
   - Response: res_valid at T+2, res_data=res_exact=130, res_id=0, stat_ops=1, stat_err_sum=0.
3. Subtraction wrap: in1=5, in2=9, add_sub=1 -> res_exact=16380 (0x3FFC, W=13). Exact build gives err=0; an approximate build gives err equal to the bench-computed |approx-exact|, accumulated correctly.
4. Round-robin: req_valid=4'hF held, res_ready=1 -> grants/res_id sequence 0,1,2,3,0,1. Each req_ready is a one-cycle pulse, spaced 3 cycles apart.
5. Backpressure: res_ready=0 for 5 cycles in RESP -> res_valid, res_data and res_id stay constant, req_ready=0 throughout. Raise res_ready -> stat_ops increments once, IDLE next cycle.
6. Mid-op reset and clear:
   - Assert rst=0 in EXEC -> outputs 0 immediately, operation lost.
   - Separately, stat_clear coincident with a handshake -> stat_ops=0, stat_err_sum=0, stat_err_max=0 afterwards.
